// File: rtl/game_state_fsm.sv
// Game-state controller: tracks lives, score and a post-hit hold window, and drives the
// message selector and motion gate from a Moore FSM (IDLE/PLAY/HIT/DEAD/WIN).
module game_state_fsm #(
  parameter int LIVES     = 3,
  parameter int SCORE_W   = 8,
  parameter int WIN_SCORE = 100,
  parameter int HIT_HOLD  = 100_000_000,
  parameter int LIVES_W   = $clog2(LIVES + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               eq,
  input  logic               point,
  output logic [2:0]         wordsel,
  output logic [LIVES_W-1:0] lives,
  output logic [SCORE_W-1:0] score,
  output logic               playing
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PLAY = 3'd1;
  localparam logic [2:0] S_HIT  = 3'd2;
  localparam logic [2:0] S_DEAD = 3'd3;
  localparam logic [2:0] S_WIN  = 3'd4;

  localparam int HOLD_W = (HIT_HOLD > 1) ? $clog2(HIT_HOLD) : 1;

  localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(LIVES);
  localparam logic [LIVES_W-1:0] LIVES_ONE  = LIVES_W'(1);
  localparam logic [SCORE_W-1:0] SCORE_LAST = SCORE_W'(WIN_SCORE - 1);
  localparam logic [SCORE_W-1:0] SCORE_ONE  = SCORE_W'(1);
  localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(HIT_HOLD - 1);
  localparam logic [HOLD_W-1:0]  HOLD_ONE   = HOLD_W'(1);

  logic [2:0]        state;
  logic [HOLD_W-1:0] hold_cnt;
  logic              start_q;
  logic              eq_q;
  logic              start_e;
  logic              eq_e;

  assign start_e = start & ~start_q;
  assign eq_e    = eq & ~eq_q;

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      lives    <= LIVES_INIT;
      score    <= '0;
      hold_cnt <= '0;
      start_q  <= 1'b0;
      eq_q     <= 1'b0;
    end else begin
      // Edge-detect history tracks the inputs in every state, so a level held
      // through HIT/DEAD/WIN cannot fire when the FSM comes back.
      start_q <= start;
      eq_q    <= eq;
      case (state)
        S_IDLE: begin
          if (start_e) begin
            state <= S_PLAY;
            lives <= LIVES_INIT;
            score <= '0;
          end
        end
        S_PLAY: begin
          if (eq_e) begin
            if (lives == LIVES_ONE) begin
              state <= S_DEAD;
              lives <= '0;
            end else begin
              state    <= S_HIT;
              lives    <= lives - LIVES_ONE;
              hold_cnt <= '0;
            end
          end else if (point) begin
            score <= score + SCORE_ONE;
            if (score == SCORE_LAST) state <= S_WIN;
          end
        end
        S_HIT: begin
          if (hold_cnt == HOLD_LAST) begin
            state <= S_PLAY;
          end else begin
            hold_cnt <= hold_cnt + HOLD_ONE;
          end
        end
        S_DEAD, S_WIN: begin
          if (start_e) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // NOTE: combinational outputs get defaults first so no path through the case infers a latch.
  always_comb begin
    wordsel = 3'd0;
    playing = 1'b0;
    case (state)
      S_PLAY: begin
        wordsel = 3'd1;
        playing = 1'b1;
      end
      S_HIT:   wordsel = 3'd2;
      S_DEAD:  wordsel = 3'd3;
      S_WIN:   wordsel = 3'd4;
      default: wordsel = 3'd0;
    endcase
  end

endmodule
